// File: rtl/ysyx_22040759_pkg.sv
// Shared types and constants for the NPC decode/execute boundary.
// The entry struct is the payload carried from ID through EX to WB.
package ysyx_22040759_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    localparam logic ALU_OR  = 1'b0;
    localparam logic ALU_ADD = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic            use_rs1;
        logic            use_rs2;
        logic            alusel;
        logic [RIDX-1:0] rd;
        logic            rd_wen;
    } idex_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    typedef enum logic [1:0] {
        HEAD_HOLD,
        HEAD_FROM_IN,
        HEAD_FROM_SKID
    } head_src_e;

    // Reference ALU behaviour for the two supported operations.
    function automatic logic [XLEN-1:0] alu_eval(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic            sel);
        case (sel)
            ALU_ADD: alu_eval = a + b;
            ALU_OR:  alu_eval = a | b;
            default: alu_eval = '0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040759_fwd_mux.sv
// Write-back forwarding for one operand: substitutes wb_data when the
// operand reads the register being written this cycle (x0 never forwards).
module ysyx_22040759_fwd_mux
    import ysyx_22040759_pkg::*;
(
    input  logic [XLEN-1:0] val,
    input  logic [RIDX-1:0] rs,
    input  logic            use_rs,
    input  logic            wb_wen,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd
);

    logic hit;

    assign hit = wb_wen && use_rs && (rs == wb_rd) && (wb_rd != '0);
    assign fwd = hit ? wb_data : val;

endmodule

// File: rtl/ysyx_22040759_idex_stage.sv
// ID/EX pipeline stage: 2-entry skid buffer (head + skid) with registered
// in_ready, write-back forwarding on every held operand and synchronous flush.
module ysyx_22040759_idex_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [RIDX-1:0] in_rs1,
    input  logic [RIDX-1:0] in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic            in_alusel,
    input  logic [RIDX-1:0] in_rd,
    input  logic            in_rd_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic            out_alusel,
    output logic [RIDX-1:0] out_rd,
    output logic            out_rd_wen,
    input  logic            wb_wen,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);

    import ysyx_22040759_pkg::*;

    occ_e        state_q, state_d;
    head_src_e   head_src;
    logic        skid_load;
    logic        accept, pop;
    idex_entry_t head_q, skid_q;
    idex_entry_t in_f, head_f, skid_f;
    logic [XLEN-1:0] in_fwd1, in_fwd2, head_fwd1, head_fwd2, skid_fwd1, skid_fwd2;

    // Both valid bits and in_ready come straight from the occupancy register.
    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    ysyx_22040759_fwd_mux u_fwd_in1   (.val(in_src1),     .rs(in_rs1),      .use_rs(in_use_rs1),
                                       .wb_wen(wb_wen),   .wb_rd(wb_rd),    .wb_data(wb_data), .fwd(in_fwd1));
    ysyx_22040759_fwd_mux u_fwd_in2   (.val(in_src2),     .rs(in_rs2),      .use_rs(in_use_rs2),
                                       .wb_wen(wb_wen),   .wb_rd(wb_rd),    .wb_data(wb_data), .fwd(in_fwd2));
    ysyx_22040759_fwd_mux u_fwd_head1 (.val(head_q.src1), .rs(head_q.rs1),  .use_rs(head_q.use_rs1),
                                       .wb_wen(wb_wen),   .wb_rd(wb_rd),    .wb_data(wb_data), .fwd(head_fwd1));
    ysyx_22040759_fwd_mux u_fwd_head2 (.val(head_q.src2), .rs(head_q.rs2),  .use_rs(head_q.use_rs2),
                                       .wb_wen(wb_wen),   .wb_rd(wb_rd),    .wb_data(wb_data), .fwd(head_fwd2));
    ysyx_22040759_fwd_mux u_fwd_skid1 (.val(skid_q.src1), .rs(skid_q.rs1),  .use_rs(skid_q.use_rs1),
                                       .wb_wen(wb_wen),   .wb_rd(wb_rd),    .wb_data(wb_data), .fwd(skid_fwd1));
    ysyx_22040759_fwd_mux u_fwd_skid2 (.val(skid_q.src2), .rs(skid_q.rs2),  .use_rs(skid_q.use_rs2),
                                       .wb_wen(wb_wen),   .wb_rd(wb_rd),    .wb_data(wb_data), .fwd(skid_fwd2));

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        in_f = '{src1: in_fwd1, src2: in_fwd2, rs1: in_rs1, rs2: in_rs2,
                 use_rs1: in_use_rs1, use_rs2: in_use_rs2, alusel: in_alusel,
                 rd: in_rd, rd_wen: in_rd_wen};
        head_f      = head_q;
        head_f.src1 = head_fwd1;
        head_f.src2 = head_fwd2;
        skid_f      = skid_q;
        skid_f.src1 = skid_fwd1;
        skid_f.src2 = skid_fwd2;
    end

    always_comb begin
        state_d   = state_q;
        head_src  = HEAD_HOLD;
        skid_load = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d  = OCC_ONE;
                    head_src = HEAD_FROM_IN;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    head_src = HEAD_FROM_IN;
                end else if (accept) begin
                    state_d   = OCC_FULL;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    state_d  = OCC_ONE;
                    head_src = HEAD_FROM_SKID;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        if (flush) begin
            state_d = OCC_EMPTY;
        end
    end

    // NOTE: clocked state uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            // NOTE: payload is reset as well because it drives the outputs directly.
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (!flush) begin
                case (head_src)
                    HEAD_FROM_IN:   head_q <= in_f;
                    HEAD_FROM_SKID: head_q <= skid_f;
                    default:        head_q <= head_f;
                endcase
                skid_q <= skid_load ? in_f : skid_f;
            end
        end
    end

    assign out_src1   = head_q.src1;
    assign out_src2   = head_q.src2;
    assign out_alusel = head_q.alusel;
    assign out_rd     = head_q.rd;
    assign out_rd_wen = head_q.rd_wen;

endmodule

// File: tb/tb_ysyx_22040759_idex_stage.sv
// Scoreboard bench for the ID/EX skid stage: directed stimulus pushes expected
// entries; a negedge monitor pops and compares every output handshake.
module tb_ysyx_22040759_idex_stage;

    import ysyx_22040759_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_src1, in_src2;
    logic [RIDX-1:0] in_rs1, in_rs2;
    logic            in_use_rs1, in_use_rs2, in_alusel;
    logic [RIDX-1:0] in_rd;
    logic            in_rd_wen;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_src1, out_src2;
    logic            out_alusel;
    logic [RIDX-1:0] out_rd;
    logic            out_rd_wen;
    logic            wb_wen;
    logic [RIDX-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    int checks = 0;
    int errors = 0;
    idex_entry_t exp_q[$];

    ysyx_22040759_idex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_alusel(in_alusel), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2),
        .out_alusel(out_alusel), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic idex_entry_t mk(input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                                       input logic [RIDX-1:0] r1, input logic [RIDX-1:0] r2,
                                       input logic u1, input logic u2, input logic sel,
                                       input logic [RIDX-1:0] rd, input logic wen);
        mk = '{src1: s1, src2: s2, rs1: r1, rs2: r2, use_rs1: u1, use_rs2: u2,
               alusel: sel, rd: rd, rd_wen: wen};
    endfunction

    task automatic offer(input idex_entry_t e);
        in_valid   = 1'b1;
        in_src1    = e.src1;
        in_src2    = e.src2;
        in_rs1     = e.rs1;
        in_rs2     = e.rs2;
        in_use_rs1 = e.use_rs1;
        in_use_rs2 = e.use_rs2;
        in_alusel  = e.alusel;
        in_rd      = e.rd;
        in_rd_wen  = e.rd_wen;
    endtask

    task automatic wb(input logic [RIDX-1:0] rd, input logic [XLEN-1:0] data);
        wb_wen  = 1'b1;
        wb_rd   = rd;
        wb_data = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid & ready hold at negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                idex_entry_t e;
                e = exp_q.pop_front();
                check("pop_data", {out_src1, out_src2, out_alusel, out_rd, out_rd_wen},
                      {e.src1, e.src2, e.alusel, e.rd, e.rd_wen});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idex_entry_t a, b, c, d, e, f, burst[4];
        rst = 1'b1;
        in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_alusel = 1'b0; in_rd = '0; in_rd_wen = 1'b0;
        out_ready = 1'b0; wb_wen = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_outputs", {out_src1, out_src2, out_alusel, out_rd, out_rd_wen}, '0);

        // Basic ADD: 5 + 7, one-cycle latency
        step();
        out_ready = 1'b1;
        a = mk(32'd5, 32'd7, 5'd0, 5'd0, 1'b0, 1'b0, ALU_ADD, 5'd1, 1'b1);
        offer(a); exp_q.push_back(a);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_src1", out_src1, 32'd5);
        check("lat_src2", out_src2, 32'd7);
        check("lat_alusel", out_alusel, 1'b1);
        check("alu_result", alu_eval(out_src1, out_src2, out_alusel), 32'd12);
        step();

        // Back-to-back throughput with out_ready held high
        burst[0] = mk(32'h100, 32'h1, 5'd0, 5'd0, 1'b0, 1'b0, ALU_OR,  5'd2, 1'b1);
        burst[1] = mk(32'h200, 32'h2, 5'd0, 5'd0, 1'b0, 1'b0, ALU_ADD, 5'd3, 1'b0);
        burst[2] = mk(32'h300, 32'h3, 5'd0, 5'd0, 1'b0, 1'b0, ALU_OR,  5'd4, 1'b1);
        burst[3] = mk(32'h400, 32'h4, 5'd0, 5'd0, 1'b0, 1'b0, ALU_ADD, 5'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            offer(burst[i]); exp_q.push_back(burst[i]);
            @(negedge clk);
            check("burst_in_ready", in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
        step();

        // Stall: A to head, B to skid, C held off by in_ready
        out_ready = 1'b0;
        a = mk(32'hA, 32'hA0, 5'd0, 5'd0, 1'b0, 1'b0, ALU_ADD, 5'd6, 1'b1);
        b = mk(32'hB, 32'hB0, 5'd0, 5'd0, 1'b0, 1'b0, ALU_OR,  5'd7, 1'b1);
        c = mk(32'hC, 32'hC0, 5'd0, 5'd0, 1'b0, 1'b0, ALU_ADD, 5'd8, 1'b0);
        offer(a); exp_q.push_back(a); step();
        offer(b); exp_q.push_back(b); step();
        offer(c); exp_q.push_back(c);
        @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        check("full_head_src1", out_src1, 32'hA);
        step();
        @(negedge clk);
        check("held_in_ready", in_ready, 1'b0);
        check("held_out_valid", out_valid, 1'b1);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("after_pop_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        step();

        // Forwarding into held head (rs1=3) and skid (rs2=5); wb_rd=0 never forwards
        out_ready = 1'b0;
        d = mk(32'h11, 32'h22, 5'd3, 5'd0, 1'b1, 1'b1, ALU_OR,  5'd9,  1'b1);
        e = mk(32'h33, 32'h44, 5'd0, 5'd5, 1'b1, 1'b1, ALU_ADD, 5'd10, 1'b1);
        offer(d); exp_q.push_back(mk(32'hDEADBEEF, 32'h22, 5'd3, 5'd0, 1'b1, 1'b1, ALU_OR, 5'd9, 1'b1));
        step();
        offer(e); exp_q.push_back(mk(32'h33, 32'hCAFE, 5'd0, 5'd5, 1'b1, 1'b1, ALU_ADD, 5'd10, 1'b1));
        step();
        in_valid = 1'b0;
        wb(5'd3, 32'hDEADBEEF);
        step();
        wb_wen = 1'b0;
        @(negedge clk);
        check("fwd_head_src1", out_src1, 32'hDEADBEEF);
        wb(5'd0, 32'h12345678);
        step();
        wb_wen = 1'b0;
        @(negedge clk);
        check("x0_no_fwd_src1", out_src1, 32'hDEADBEEF);
        check("x0_no_fwd_src2", out_src2, 32'h22);
        wb(5'd5, 32'hCAFE);
        step();
        wb_wen = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Forwarding on capture: rs2=8 written back in the accept cycle
        f = mk(32'h1, 32'h99, 5'd0, 5'd8, 1'b0, 1'b1, ALU_ADD, 5'd11, 1'b1);
        offer(f); exp_q.push_back(mk(32'h1, 32'h10, 5'd0, 5'd8, 1'b0, 1'b1, ALU_ADD, 5'd11, 1'b1));
        wb(5'd8, 32'h10);
        step();
        in_valid = 1'b0;
        wb_wen = 1'b0;
        @(negedge clk);
        check("fwd_capture_src2", out_src2, 32'h10);
        step();

        // Flush while FULL with a new offer: everything dropped
        out_ready = 1'b0;
        offer(mk(32'h51, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, ALU_OR, 5'd12, 1'b1)); step();
        offer(mk(32'h52, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, ALU_OR, 5'd13, 1'b1)); step();
        offer(mk(32'h53, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, ALU_OR, 5'd14, 1'b1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        step();
        step();

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        offer(mk(32'hAAAA, 32'hBBBB, 5'd1, 5'd2, 1'b1, 1'b1, ALU_ADD, 5'd15, 1'b1)); step();
        offer(mk(32'hCCCC, 32'hDDDD, 5'd1, 5'd2, 1'b1, 1'b1, ALU_OR,  5'd16, 1'b1)); step();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_in_ready", in_ready, 1'b0);
        check("pre_rst_src1", out_src1, 32'hAAAA);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_outputs", {out_src1, out_src2, out_alusel, out_rd, out_rd_wen}, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First accept right after reset release
        out_ready = 1'b1;
        a = mk(32'h77, 32'h88, 5'd0, 5'd0, 1'b0, 1'b0, ALU_OR, 5'd17, 1'b1);
        offer(a); exp_q.push_back(a);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b1);
        step();
        step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
